// File: rtl/pseudo_pkg.sv
// Shared PRBS definitions: word width, the LFSR step function and the
// checker state encoding. Also used by the matching LFSR generator.
package pseudo_pkg;

    localparam int PRBS_WIDTH = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    // One LFSR advance: rotate with feedback taps into bits 2 and 15.
    function automatic logic [PRBS_WIDTH-1:0] prbs_step(input logic [PRBS_WIDTH-1:0] q);
        logic [PRBS_WIDTH-1:0] n;
        n       = q;
        n[0]    = q[15];
        n[1]    = q[0];
        n[2]    = q[1] ^ q[15];
        n[14:3] = q[13:2];
        n[15]   = q[14] ^ q[15];
        return n;
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS checker: hunts for a seed in the received stream, verifies
// LOCK_COUNT consecutive predictions, then free-runs its reference while
// LOCKED, counting checked words and mismatches (both saturating).
module prbs_checker
    import pseudo_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [PRBS_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  clear_in,
    output logic                  locked_out,
    output logic                  error_out,
    output logic [15:0]           err_count_out,
    output logic [15:0]           word_count_out
);

    localparam int         CNT_W        = 4;
    localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_COUNT);

    prbs_state_e           state_q, state_d;
    logic [PRBS_WIDTH-1:0] expected_q, expected_d;
    logic [CNT_W-1:0]      match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;
    logic                  locked_q, locked_d;
    logic                  error_q, error_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [15:0]           word_cnt_q, word_cnt_d;

    logic                  word_match;
    logic [CNT_W-1:0]      match_inc;
    logic [CNT_W-1:0]      miss_inc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign word_match = (data_in == expected_q);
    assign match_inc  = match_cnt_q + 4'd1;
    assign miss_inc   = miss_cnt_q + 4'd1;

    // Next-state: hunt/verify/lock sequencing, reference advance and counters.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        error_d     = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;

        if (valid_in) begin
            case (state_q)
                HUNT: begin
                    // All-zero is the LFSR lock-up value and cannot seed a sequence.
                    if (data_in != '0) begin
                        expected_d  = prbs_step(data_in);
                        match_cnt_d = '0;
                        state_d     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (word_match) begin
                        match_cnt_d = match_inc;
                        expected_d  = prbs_step(expected_q);
                        if (match_inc == LOCK_CNT_C) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        expected_d  = prbs_step(data_in);
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running reference: advance whatever the compare says.
                    expected_d = prbs_step(expected_q);
                    word_cnt_d = sat_inc(word_cnt_q);
                    if (!word_match) begin
                        error_d    = 1'b1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        miss_cnt_d = miss_inc;
                        if (miss_inc == UNLOCK_CNT_C) begin
                            state_d = HUNT;
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Clear beats any coincident count event.
        if (clear_in) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign locked_out     = locked_q;
    assign error_out      = error_q;
    assign err_count_out  = err_cnt_q;
    assign word_count_out = word_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: behavioural reference model with a
// per-cycle compare, randomized stimulus and directed lock/unlock scenarios.
module tb_prbs_checker;

    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 8;

    logic        clk_in   = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        valid_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [15:0] data_in  = 16'h0000;
    logic        locked_out;
    logic        error_out;
    logic [15:0] err_count_out;
    logic [15:0] word_count_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] gen;

    prbs_checker #(
        .LOCK_COUNT  (LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .clear_in      (clear_in),
        .locked_out    (locked_out),
        .error_out     (error_out),
        .err_count_out (err_count_out),
        .word_count_out(word_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference step: rotate left by one, then fold the feedback into bits 15 and 2.
    function automatic logic [15:0] ref_step(input logic [15:0] q);
        logic [15:0] n;
        n = {q[14:0], q[15]};
        if (q[15]) n = n ^ 16'h8004;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode;   // 0 hunting, 1 verifying, 2 locked
    int          m_match;
    int          m_miss;
    int          m_errc;
    int          m_wordc;
    logic [15:0] m_exp;
    logic        m_locked;
    logic        m_err;

    always @(posedge clk_in or negedge rst_n_in) begin : mdl
        int          mode, match, miss, errc, wordc;
        logic [15:0] ex;
        logic        er;
        if (!rst_n_in) begin
            m_mode   <= 0;
            m_match  <= 0;
            m_miss   <= 0;
            m_errc   <= 0;
            m_wordc  <= 0;
            m_exp    <= 16'h0000;
            m_locked <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            mode  = m_mode;
            match = m_match;
            miss  = m_miss;
            errc  = m_errc;
            wordc = m_wordc;
            ex    = m_exp;
            er    = 1'b0;
            if (valid_in) begin
                if (mode == 0) begin
                    if (data_in != 16'h0000) begin
                        ex    = ref_step(data_in);
                        match = 0;
                        mode  = 1;
                    end
                end else if (mode == 1) begin
                    if (data_in == ex) begin
                        match = match + 1;
                        ex    = ref_step(ex);
                        if (match == LOCK_COUNT) begin
                            mode = 2;
                            miss = 0;
                        end
                    end else begin
                        ex    = ref_step(data_in);
                        match = 0;
                    end
                end else begin
                    wordc = (wordc < 65535) ? wordc + 1 : 65535;
                    if (data_in != ex) begin
                        er   = 1'b1;
                        errc = (errc < 65535) ? errc + 1 : 65535;
                        miss = miss + 1;
                        if (miss == UNLOCK_COUNT) mode = 0;
                    end else begin
                        miss = 0;
                    end
                    ex = ref_step(ex);
                end
            end
            if (clear_in) begin
                errc  = 0;
                wordc = 0;
            end
            m_mode   <= mode;
            m_match  <= match;
            m_miss   <= miss;
            m_errc   <= errc;
            m_wordc  <= wordc;
            m_exp    <= ex;
            m_locked <= (mode == 2);
            m_err    <= er;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk_in) begin
        if (rst_n_in) begin
            chk("locked_out", {31'd0, locked_out}, {31'd0, m_locked});
            chk("error_out", {31'd0, error_out}, {31'd0, m_err});
            chk("err_count_out", {16'd0, err_count_out}, m_errc);
            chk("word_count_out", {16'd0, word_count_out}, m_wordc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic v, input logic [15:0] d, input logic c);
        valid_in = v;
        data_in  = d;
        clear_in = c;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        clear_in = 1'b0;
        data_in  = 16'($urandom);
    endtask

    task automatic good();
        beat(1'b1, gen, 1'b0);
        gen = ref_step(gen);
    endtask

    task automatic bad();
        beat(1'b1, gen ^ 16'h0001, 1'b0);
        gen = ref_step(gen);
    endtask

    task automatic idle();
        beat(1'b0, 16'($urandom), 1'b0);
    endtask

    initial begin : wdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit          v, c;
        logic [15:0] w;

        // Pin the reference step against hand-computed values.
        chk("step_4000", {16'd0, ref_step(16'h4000)}, 32'h8000);
        chk("step_8000", {16'd0, ref_step(16'h8000)}, 32'h8005);
        chk("step_8005", {16'd0, ref_step(16'h8005)}, 32'h800F);

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_locked", {31'd0, locked_out}, 0);
        chk("rst_error", {31'd0, error_out}, 0);
        chk("rst_err_count", {16'd0, err_count_out}, 0);
        chk("rst_word_count", {16'd0, word_count_out}, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Zero words in HUNT are ignored; lock then still needs exactly 1+LOCK_COUNT words.
        repeat (3) beat(1'b1, 16'h0000, 1'b0);
        chk("zero_hunt_locked", {31'd0, locked_out}, 0);
        gen = 16'h4000;
        repeat (LOCK_COUNT) good();
        chk("lock_before_5th", {31'd0, locked_out}, 0);
        good();
        chk("lock_at_5th", {31'd0, locked_out}, 1);
        chk("lock_word_count", {16'd0, word_count_out}, 0);

        // Single bit-0 error while locked.
        bad();
        chk("single_err_pulse", {31'd0, error_out}, 1);
        chk("single_err_count", {16'd0, err_count_out}, 1);
        repeat (10) good();
        chk("single_err_hold", {16'd0, err_count_out}, 1);
        chk("single_err_locked", {31'd0, locked_out}, 1);

        // Idle gaps between words: only valid beats count.
        beat(1'b0, 16'h0000, 1'b1);
        repeat (6) begin
            good();
            idle();
            idle();
        end
        chk("gap_word_count", {16'd0, word_count_out}, 6);
        chk("gap_err_count", {16'd0, err_count_out}, 0);

        // Randomized traffic: gaps, random bit corruption, occasional clear.
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(3, 0) != 0);
            c = ($urandom_range(31, 0) == 0);
            w = gen;
            if (v) begin
                if ($urandom_range(15, 0) == 0) w = gen ^ (16'h0001 << $urandom_range(15, 0));
                beat(1'b1, w, c);
                gen = ref_step(gen);
            end else begin
                beat(1'b0, 16'($urandom), c);
            end
        end

        // Loss of lock: 7 bad + 1 good holds, 8 bad drops.
        repeat (6) good();
        chk("relock_a", {31'd0, locked_out}, 1);
        beat(1'b0, 16'h0000, 1'b1);
        repeat (7) bad();
        good();
        chk("seven_bad_hold", {31'd0, locked_out}, 1);
        chk("seven_bad_count", {16'd0, err_count_out}, 7);
        beat(1'b0, 16'h0000, 1'b1);
        repeat (7) bad();
        chk("seventh_bad_locked", {31'd0, locked_out}, 1);
        bad();
        chk("eight_bad_unlock", {31'd0, locked_out}, 0);
        chk("eight_bad_count", {16'd0, err_count_out}, 8);

        // Saturation via long corruption with lock held by a good word every 8th.
        repeat (6) good();
        chk("relock_b", {31'd0, locked_out}, 1);
        repeat (9400) begin
            repeat (7) bad();
            good();
        end
        chk("sat_err_count", {16'd0, err_count_out}, 32'hFFFF);
        chk("sat_word_count", {16'd0, word_count_out}, 32'hFFFF);
        chk("sat_locked", {31'd0, locked_out}, 1);
        bad();
        chk("sat_err_hold", {16'd0, err_count_out}, 32'hFFFF);

        // Clear coinciding with a mismatch: clear wins.
        beat(1'b1, gen ^ 16'h0001, 1'b1);
        gen = ref_step(gen);
        chk("clear_err_count", {16'd0, err_count_out}, 0);
        chk("clear_word_count", {16'd0, word_count_out}, 0);
        chk("clear_err_pulse", {31'd0, error_out}, 1);

        // Asynchronous reset mid-lock, between clock edges.
        repeat (3) good();
        bad();
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_locked", {31'd0, locked_out}, 0);
        chk("async_error", {31'd0, error_out}, 0);
        chk("async_err_count", {16'd0, err_count_out}, 0);
        chk("async_word_count", {16'd0, word_count_out}, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        gen = 16'($urandom_range(65535, 1));
        repeat (LOCK_COUNT) good();
        chk("post_rst_not_locked", {31'd0, locked_out}, 0);
        good();
        chk("post_rst_locked", {31'd0, locked_out}, 1);

        idle();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
